// File: rtl/dff_stimulus_checker.sv
// On-chip BIST for a D flip-flop: drives an LFSR bit stream on D and checks Q LAT cycles later.
// Optional CHECK_QN_EN adds a Qn input that must always equal ~Q on every compared bit.
module dff_stimulus_checker #(
   parameter int         LEN  = 16,
   parameter int         LAT  = 2,
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       C,
   input  logic       R,
   input  logic       start,
   output logic       D,
   input  logic       Q,
`ifdef CHECK_QN_EN
   input  logic       Qn,
`endif
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [7:0] L_SEED = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [9:0] L_LAST = 10'(LEN - 1);
   localparam logic [9:0] L_FLSH = 10'(LAT - 1);

   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [9:0]       r_cnt;
   logic [LAT-1:0]   r_vld_pipe;
   logic [LAT-1:0]   r_exp_pipe;
   logic             w_bad;
   logic [7:0]       w_err_nxt;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
   endfunction

   // Q is compared combinationally; the LAT pipeline is the only alignment delay.
`ifdef CHECK_QN_EN
   assign w_bad = (Q != r_exp_pipe[LAT-1]) || (Qn == Q);
`else
   assign w_bad = (Q != r_exp_pipe[LAT-1]);
`endif

   assign w_err_nxt = (r_vld_pipe[LAT-1] && w_bad && err_cnt != 8'hFF) ?
                      err_cnt + 8'd1 : err_cnt;

   always_ff @(posedge C) begin
      if (R) begin
         r_state    <= S_IDLE;
         r_lfsr     <= L_SEED;
         r_cnt      <= '0;
         r_vld_pipe <= '0;
         r_exp_pipe <= '0;
         D          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
      end else begin
         for (int k = LAT - 1; k > 0; k--) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_exp_pipe[k] <= r_exp_pipe[k-1];
         end
         r_vld_pipe[0] <= 1'b0;
         r_exp_pipe[0] <= 1'b0;
         err_cnt       <= w_err_nxt;
         done          <= 1'b0;
         case (r_state)
            S_IDLE: begin
               D <= 1'b0;
               if (start) begin
                  err_cnt       <= '0;
                  pass          <= 1'b0;
                  D             <= L_SEED[0];
                  r_lfsr        <= lfsr_step(L_SEED);
                  r_vld_pipe[0] <= 1'b1;
                  r_exp_pipe[0] <= L_SEED[0];
                  busy          <= 1'b1;
                  r_cnt         <= (LEN == 1) ? 10'd0 : 10'd1;
                  r_state       <= (LEN == 1) ? S_FLUSH : S_RUN;
               end
            end
            S_RUN: begin
               D             <= r_lfsr[0];
               r_lfsr        <= lfsr_step(r_lfsr);
               r_vld_pipe[0] <= 1'b1;
               r_exp_pipe[0] <= r_lfsr[0];
               if (r_cnt == L_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_FLUSH;
               end else begin
                  r_cnt <= r_cnt + 10'd1;
               end
            end
            S_FLUSH: begin
               D <= 1'b0;
               // Exit on the edge that retires the last compare so pass sees it.
               if (r_cnt == L_FLSH) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (w_err_nxt == 8'd0);
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 10'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dff_stimulus_checker.sv
// Directed bench: four checker instances (LEN 16/8/300/1) each beside a behavioural DFF.
module tb_dff_stimulus_checker;

   logic       C;
   logic [3:0] st, rr, dd, bz, dn, ps, q_ff, qq, qn;
   logic [7:0] ec [4];
   logic [1:0] qm [4];
   logic [3:0] qnm;

   int n_tot = 0;
   int n_bad = 0;

   int          first, npulse, pre_err;
   logic [63:0] dseq;
   logic        busy_dn, d_dn, r_busy, r_d;
   logic [7:0]  r_err;

   initial C = 1'b0;
   always #5 C = ~C;

   always @(posedge C) q_ff <= dd;

   always_comb begin
      qq = '0;
      qn = '0;
      for (int i = 0; i < 4; i++) begin
         case (qm[i])
            2'd1:    qq[i] = 1'b0;
            2'd2:    qq[i] = ~q_ff[i];
            default: qq[i] = q_ff[i];
         endcase
         qn[i] = qnm[i] ? qq[i] : ~qq[i];
      end
   end

   dff_stimulus_checker #(.LEN(16), .LAT(2), .SEED(8'hA5)) u_c16 (
      .C(C), .R(rr[0]), .start(st[0]), .D(dd[0]), .Q(qq[0]),
`ifdef CHECK_QN_EN
      .Qn(qn[0]),
`endif
      .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_cnt(ec[0]));

   dff_stimulus_checker #(.LEN(8), .LAT(2), .SEED(8'hA5)) u_c8 (
      .C(C), .R(rr[1]), .start(st[1]), .D(dd[1]), .Q(qq[1]),
`ifdef CHECK_QN_EN
      .Qn(qn[1]),
`endif
      .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_cnt(ec[1]));

   dff_stimulus_checker #(.LEN(300), .LAT(2), .SEED(8'hA5)) u_c300 (
      .C(C), .R(rr[2]), .start(st[2]), .D(dd[2]), .Q(qq[2]),
`ifdef CHECK_QN_EN
      .Qn(qn[2]),
`endif
      .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_cnt(ec[2]));

   dff_stimulus_checker #(.LEN(1), .LAT(2), .SEED(8'hA5)) u_c1 (
      .C(C), .R(rr[3]), .start(st[3]), .D(dd[3]), .Q(qq[3]),
`ifdef CHECK_QN_EN
      .Qn(qn[3]),
`endif
      .busy(bz[3]), .done(dn[3]), .pass(ps[3]), .err_cnt(ec[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after the edge that sampled start.
   task automatic start_run(input int idx);
      @(negedge C) st[idx] = 1'b1;
      @(negedge C) st[idx] = 1'b0;
   endtask

   // first = edges after the start edge when done was first seen; -1 if never.
   task automatic wait_done(input int idx, input int maxc, input int pulse_at, input int rst_at);
      first = -1; npulse = 0; dseq = '0; dseq[0] = dd[idx];
      pre_err = -1; busy_dn = 1'bx; d_dn = 1'bx;
      for (int k = 0; k < maxc; k++) begin
         if (k == pulse_at) st[idx] = 1'b1;
         else if (k == pulse_at + 1) st[idx] = 1'b0;
         if (k == rst_at) rr[idx] = 1'b1;
         else if (k == rst_at + 1) rr[idx] = 1'b0;
         @(negedge C);
         if (k < 63) dseq[k+1] = dd[idx];
         if (k == rst_at - 1) pre_err = int'(ec[idx]);
         if (k == rst_at) begin
            r_busy = bz[idx]; r_err = ec[idx]; r_d = dd[idx];
         end
         if (dn[idx]) begin
            if (first < 0) begin
               first = k + 1; busy_dn = bz[idx]; d_dn = dd[idx];
            end
            npulse++;
         end
      end
   endtask

   initial begin
      rr = '1; st = '0; qnm = '0;
      for (int i = 0; i < 4; i++) qm[i] = 2'd0;
      repeat (3) @(negedge C);
      chk("rst_busy", bz[0], 0);
      chk("rst_done", dn[0], 0);
      chk("rst_pass", ps[0], 0);
      chk("rst_err",  ec[0], 0);
      chk("rst_d",    dd[0], 0);
      rr = '0;

      // LEN=16 loopback
      start_run(0);
      wait_done(0, 40, -10, -10);
      chk("l16_dseq",  dseq[15:0], 16'h72A5);
      chk("l16_first", first, 17);
      chk("l16_npls",  npulse, 1);
      chk("l16_busy",  busy_dn, 0);
      chk("l16_d",     d_dn, 0);
      chk("l16_err",   ec[0], 0);
      chk("l16_pass",  ps[0], 1);
      repeat (3) @(negedge C);
      chk("l16_hold",  ps[0], 1);

      // second run: pass cleared at start, restart mid-run ignored
      start_run(0);
      chk("l16_pclr",  ps[0], 0);
      chk("l16_busy1", bz[0], 1);
      wait_done(0, 40, 2, -10);
      chk("ign_first", first, 17);
      chk("ign_npls",  npulse, 1);
      chk("ign_pass",  ps[0], 1);

      // reset 5 cycles into a run with Q tied low
      qm[0] = 2'd1;
      start_run(0);
      wait_done(0, 30, -10, 4);
      chk("rr_pre_err", pre_err, 2);
      chk("rr_busy", r_busy, 0);
      chk("rr_err",  r_err, 0);
      chk("rr_d",    r_d, 0);
      chk("rr_npls", npulse, 0);
      qm[0] = 2'd0;
      start_run(0);
      wait_done(0, 30, -10, -10);
      chk("rr_run_first", first, 17);
      chk("rr_run_pass",  ps[0], 1);

      // LEN=8, Q tied low
      qm[1] = 2'd1;
      start_run(1);
      wait_done(1, 20, -10, -10);
      chk("q0_first", first, 9);
      chk("q0_err",   ec[1], 4);
      chk("q0_pass",  ps[1], 0);
      qm[1] = 2'd0;
      start_run(1);
      wait_done(1, 20, -10, -10);
      chk("q0_rerun_err",  ec[1], 0);
      chk("q0_rerun_pass", ps[1], 1);

      // LEN=300, inverted Q saturates
      qm[2] = 2'd2;
      start_run(2);
      wait_done(2, 400, -10, -10);
      chk("sat_first", first, 301);
      chk("sat_err",   ec[2], 255);
      chk("sat_pass",  ps[2], 0);

      // LEN=1
      start_run(3);
      wait_done(3, 10, -10, -10);
      chk("one_first", first, 2);
      chk("one_err",   ec[3], 0);
      chk("one_pass",  ps[3], 1);
      qm[3] = 2'd2;
      start_run(3);
      wait_done(3, 10, -10, -10);
      chk("one_inv_err",  ec[3], 1);
      chk("one_inv_pass", ps[3], 0);
      qm[3] = 2'd0;

      // start held high: back-to-back runs every LEN+LAT+1 cycles
      @(negedge C) st[3] = 1'b1;
      wait_done(3, 12, -10, -10);
      chk("held_npls", npulse, 3);
      chk("held_first", first, 3);
      st[3] = 1'b0;
      repeat (4) @(negedge C);

      // R and start together: R wins
      @(negedge C) begin rr[3] = 1'b1; st[3] = 1'b1; end
      @(negedge C) begin rr[3] = 1'b0; st[3] = 1'b0; end
      chk("rs_busy", bz[3], 0);

`ifdef CHECK_QN_EN
      qnm[1] = 1'b1;
      start_run(1);
      wait_done(1, 20, -10, -10);
      chk("qn_err",  ec[1], 8);
      chk("qn_pass", ps[1], 0);
      qnm[1] = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
